// File: rtl/serial_text_controller_if.sv
// Bundles the UART-receiver input and text-RAM write/status outputs of the
// serial text controller; master is the controller side.
interface serial_text_controller_if #(
    parameter int ADDR_W = 12
);
    logic              rxReadyIN;
    logic [7:0]        rxDataIN;
    logic              wrEnOUT;
    logic [ADDR_W-1:0] wrAddrOUT;
    logic [7:0]        wrDataOUT;
    logic [6:0]        cursorColOUT;
    logic [4:0]        cursorRowOUT;
    logic              busyOUT;
    logic              overflowOUT;

    modport master (
        input  rxReadyIN, rxDataIN,
        output wrEnOUT, wrAddrOUT, wrDataOUT,
        output cursorColOUT, cursorRowOUT, busyOUT, overflowOUT
    );

    modport slave (
        output rxReadyIN, rxDataIN,
        input  wrEnOUT, wrAddrOUT, wrDataOUT,
        input  cursorColOUT, cursorRowOUT, busyOUT, overflowOUT
    );
endinterface

// File: rtl/serial_text_controller.sv
// Turns received UART bytes into text-RAM cell writes, tracks the cursor and
// runs a full-screen clear on form feed.
module serial_text_controller #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter logic [7:0] CLEAR_CHAR = 8'h20,
    parameter int         ADDR_W     = $clog2(COLS*ROWS)
) (
    input  logic clockIN,
    input  logic resetIN,
    serial_text_controller_if.master bus
);
    typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

    localparam int                SYNC_STAGES = 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(COLS*ROWS - 1);
    localparam logic [6:0]        LAST_COL    = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW    = 5'(ROWS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rdy_prev_q;
    logic                   rx_rise;

    state_t            state_q, state_d;
    logic              pend_valid_q, pend_valid_d;
    logic [7:0]        pend_data_q, pend_data_d;
    logic [6:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic              consume;
    logic [ADDR_W-1:0] cell_addr;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = bus.rxReadyIN;
            end else begin : g_chain
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    // One capture per frame: the level stays high until the next start bit.
    assign rx_rise   = sync_q[SYNC_STAGES-1] & ~rdy_prev_q;
    assign cell_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        col_d        = col_q;
        row_d        = row_q;
        clr_cnt_d    = clr_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = 1'b0;
        overflow_d   = overflow_q;
        consume      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    consume = 1'b1;
                    if (pend_data_q >= 8'h20 && pend_data_q <= 8'h7E) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cell_addr;
                        wr_data_d = pend_data_q;
                        if (col_q == LAST_COL) begin
                            col_d = 7'd0;
                            row_d = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (pend_data_q)
                            8'h0D: col_d = 7'd0;
                            8'h0A: row_d = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
                            8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
                            8'h0C: begin
                                state_d   = ST_CLEAR;
                                busy_d    = 1'b1;
                                clr_cnt_d = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_CLEAR: begin
                busy_d    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = CLEAR_CHAR;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    col_d   = 7'd0;
                    row_d   = 5'd0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A byte leaving the pending slot this cycle frees it for the new one.
        if (rx_rise) begin
            if (pend_valid_q && !consume) begin
                overflow_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_data_d  = bus.rxDataIN;
            end
        end else if (consume) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clockIN) begin
        if (resetIN) begin
            sync_q       <= '0;
            rdy_prev_q   <= 1'b0;
            state_q      <= ST_IDLE;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 8'h00;
            col_q        <= 7'd0;
            row_q        <= 5'd0;
            clr_cnt_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            rdy_prev_q   <= sync_q[SYNC_STAGES-1];
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            col_q        <= col_d;
            row_q        <= row_d;
            clr_cnt_q    <= clr_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.wrEnOUT      = wr_en_q;
    assign bus.wrAddrOUT    = wr_addr_q;
    assign bus.wrDataOUT    = wr_data_q;
    assign bus.cursorColOUT = col_q;
    assign bus.cursorRowOUT = row_q;
    assign bus.busyOUT      = busy_q;
    assign bus.overflowOUT  = overflow_q;
endmodule

// File: tb/tb_serial_text_controller.sv
// Directed bench for serial_text_controller: character writes, control codes,
// cursor wrap, full-screen clear, pending/overflow and reset mid-clear.
module tb_serial_text_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_text_controller_if #(.ADDR_W(12)) bus ();

    serial_text_controller #(
        .COLS(80), .ROWS(30), .CLEAR_CHAR(8'h20), .ADDR_W(12)
    ) dut (
        .clockIN (clk),
        .resetIN (rst),
        .bus     (bus)
    );

    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t log_q[$];

    always @(negedge clk) begin
        if (bus.wrEnOUT === 1'b1)
            log_q.push_back('{int'(bus.wrAddrOUT), int'(bus.wrDataOUT), cyc});
    end

    task automatic send_byte(input logic [7:0] b, input int hold, output int t0);
        @(negedge clk);
        bus.rxDataIN  = b;
        bus.rxReadyIN = 1'b1;
        t0 = cyc;
        repeat (hold) @(negedge clk);
        bus.rxReadyIN = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        int t;
        send_byte(b, 1, t);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.rxReadyIN = 1'b0;
        bus.rxDataIN  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 7;
        if (bus.wrEnOUT !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", bus.wrEnOUT); end
        if (bus.wrAddrOUT !== 12'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.wrAddrOUT); end
        if (bus.wrDataOUT !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.wrDataOUT); end
        if (bus.cursorColOUT !== 7'd0) begin failures++; $display("FAIL reset_col got=%0d exp=0", bus.cursorColOUT); end
        if (bus.cursorRowOUT !== 5'd0) begin failures++; $display("FAIL reset_row got=%0d exp=0", bus.cursorRowOUT); end
        if (bus.busyOUT !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busyOUT); end
        if (bus.overflowOUT !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.overflowOUT); end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_hello();
        int t0, t1;
        log_q.delete();
        send_byte(8'h48, 2, t0);
        send_byte(8'h69, 2, t1);
        repeat (3) @(negedge clk);
        checks++;
        if (log_q.size() != 2) begin
            failures++; $display("FAIL hello_count got=%0d exp=2", log_q.size());
        end else begin
            checks += 4;
            if (log_q[0].addr != 0 || log_q[0].data != 'h48) begin
                failures++; $display("FAIL hello_w0 got=(%0d,%h) exp=(0,48)", log_q[0].addr, log_q[0].data);
            end
            if (log_q[1].addr != 1 || log_q[1].data != 'h69) begin
                failures++; $display("FAIL hello_w1 got=(%0d,%h) exp=(1,69)", log_q[1].addr, log_q[1].data);
            end
            if (log_q[0].cyc != t0 + 4) begin
                failures++; $display("FAIL hello_lat0 got=%0d exp=%0d", log_q[0].cyc, t0 + 4);
            end
            if (log_q[1].cyc != t1 + 4) begin
                failures++; $display("FAIL hello_lat1 got=%0d exp=%0d", log_q[1].cyc, t1 + 4);
            end
        end
        checks++;
        if (bus.cursorColOUT !== 7'd2 || bus.cursorRowOUT !== 5'd0) begin
            failures++; $display("FAIL hello_cursor got=(%0d,%0d) exp=(2,0)", bus.cursorColOUT, bus.cursorRowOUT);
        end
        $display("test_hello writes=%0d cursor=(%0d,%0d)", log_q.size(), bus.cursorColOUT, bus.cursorRowOUT);
    endtask

    task automatic test_hold();
        int t;
        log_q.delete();
        send_byte(8'h5A, 1000, t);
        checks++;
        if (log_q.size() != 1 || log_q[0].addr != 2 || log_q[0].data != 'h5A) begin
            failures++; $display("FAIL hold_single got_count=%0d exp_count=1 at addr 2 data 5A", log_q.size());
        end
        log_q.delete();
        put(8'h07);
        repeat (2) @(negedge clk);
        checks += 2;
        if (log_q.size() != 0) begin failures++; $display("FAIL ignored_write got=%0d exp=0", log_q.size()); end
        if (bus.cursorColOUT !== 7'd3 || bus.cursorRowOUT !== 5'd0) begin
            failures++; $display("FAIL ignored_cursor got=(%0d,%0d) exp=(3,0)", bus.cursorColOUT, bus.cursorRowOUT);
        end
        $display("test_hold done");
    endtask

    task automatic test_cursor();
        do_reset();
        for (int i = 0; i < 29; i++) put(8'h0A);
        for (int i = 0; i < 79; i++) put(8'h61);
        checks++;
        if (bus.cursorColOUT !== 7'd79 || bus.cursorRowOUT !== 5'd29) begin
            failures++; $display("FAIL corner_cursor got=(%0d,%0d) exp=(79,29)", bus.cursorColOUT, bus.cursorRowOUT);
        end
        log_q.delete();
        put(8'h41);
        checks += 2;
        if (log_q.size() != 1 || log_q[0].addr != 2399 || log_q[0].data != 'h41) begin
            failures++; $display("FAIL corner_write got_count=%0d exp addr 2399 data 41", log_q.size());
        end
        if (bus.cursorColOUT !== 7'd0 || bus.cursorRowOUT !== 5'd0) begin
            failures++; $display("FAIL wrap_cursor got=(%0d,%0d) exp=(0,0)", bus.cursorColOUT, bus.cursorRowOUT);
        end
        for (int i = 0; i < 3; i++) put(8'h0A);
        for (int i = 0; i < 5; i++) put(8'h62);
        checks++;
        if (bus.cursorColOUT !== 7'd5 || bus.cursorRowOUT !== 5'd3) begin
            failures++; $display("FAIL setup_cursor got=(%0d,%0d) exp=(5,3)", bus.cursorColOUT, bus.cursorRowOUT);
        end
        log_q.delete();
        put(8'h0D);
        checks++;
        if (bus.cursorColOUT !== 7'd0 || bus.cursorRowOUT !== 5'd3) begin
            failures++; $display("FAIL cr_cursor got=(%0d,%0d) exp=(0,3)", bus.cursorColOUT, bus.cursorRowOUT);
        end
        put(8'h0A);
        checks++;
        if (bus.cursorColOUT !== 7'd0 || bus.cursorRowOUT !== 5'd4) begin
            failures++; $display("FAIL lf_cursor got=(%0d,%0d) exp=(0,4)", bus.cursorColOUT, bus.cursorRowOUT);
        end
        put(8'h08);
        checks++;
        if (bus.cursorColOUT !== 7'd0 || bus.cursorRowOUT !== 5'd4) begin
            failures++; $display("FAIL bs_col0 got=(%0d,%0d) exp=(0,4)", bus.cursorColOUT, bus.cursorRowOUT);
        end
        checks++;
        if (log_q.size() != 0) begin failures++; $display("FAIL ctrl_write got=%0d exp=0", log_q.size()); end
        put(8'h63);
        put(8'h08);
        checks++;
        if (bus.cursorColOUT !== 7'd0 || bus.cursorRowOUT !== 5'd4) begin
            failures++; $display("FAIL bs_col1 got=(%0d,%0d) exp=(0,4)", bus.cursorColOUT, bus.cursorRowOUT);
        end
        $display("test_cursor done cursor=(%0d,%0d)", bus.cursorColOUT, bus.cursorRowOUT);
    endtask

    task automatic test_clear();
        int bad;
        int i;
        log_q.delete();
        put(8'h0C);
        checks++;
        if (bus.busyOUT !== 1'b1) begin failures++; $display("FAIL clear_busy_high got=%b exp=1", bus.busyOUT); end
        i = 0;
        while (i < 3000 && bus.busyOUT === 1'b1) begin @(negedge clk); i++; end
        checks++;
        if (bus.busyOUT !== 1'b0) begin failures++; $display("FAIL clear_timeout busy=%b exp=0", bus.busyOUT); end
        checks++;
        if (log_q.size() != 2400) begin
            failures++; $display("FAIL clear_count got=%0d exp=2400", log_q.size());
        end else begin
            bad = 0;
            for (int k = 0; k < 2400; k++)
                if (log_q[k].addr != k || log_q[k].data != 'h20 || log_q[k].cyc != log_q[0].cyc + k) bad++;
            checks++;
            if (bad != 0) begin failures++; $display("FAIL clear_seq bad_entries=%0d exp=0", bad); end
        end
        checks++;
        if (bus.cursorColOUT !== 7'd0 || bus.cursorRowOUT !== 5'd0) begin
            failures++; $display("FAIL clear_cursor got=(%0d,%0d) exp=(0,0)", bus.cursorColOUT, bus.cursorRowOUT);
        end
        $display("test_clear writes=%0d", log_q.size());
    endtask

    task automatic test_overflow();
        int i;
        int ys;
        checks++;
        if (bus.overflowOUT !== 1'b0) begin failures++; $display("FAIL ovf_before got=%b exp=0", bus.overflowOUT); end
        log_q.delete();
        put(8'h0C);
        put(8'h58);
        put(8'h59);
        checks++;
        if (bus.overflowOUT !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", bus.overflowOUT); end
        i = 0;
        while (i < 3000 && bus.busyOUT === 1'b1) begin @(negedge clk); i++; end
        repeat (8) @(negedge clk);
        checks++;
        if (log_q.size() != 2401) begin
            failures++; $display("FAIL ovf_count got=%0d exp=2401", log_q.size());
        end else begin
            checks++;
            if (log_q[2400].addr != 0 || log_q[2400].data != 'h58) begin
                failures++; $display("FAIL pending_exec got=(%0d,%h) exp=(0,58)", log_q[2400].addr, log_q[2400].data);
            end
        end
        ys = 0;
        foreach (log_q[k]) if (log_q[k].data == 'h59) ys++;
        checks += 3;
        if (ys != 0) begin failures++; $display("FAIL dropped_written got=%0d exp=0", ys); end
        if (bus.cursorColOUT !== 7'd1 || bus.cursorRowOUT !== 5'd0) begin
            failures++; $display("FAIL ovf_cursor got=(%0d,%0d) exp=(1,0)", bus.cursorColOUT, bus.cursorRowOUT);
        end
        if (bus.overflowOUT !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflowOUT); end
        $display("test_overflow writes=%0d overflow=%b", log_q.size(), bus.overflowOUT);
    endtask

    task automatic test_reset_mid_clear();
        int n;
        int i;
        do_reset();
        checks++;
        if (bus.overflowOUT !== 1'b0) begin failures++; $display("FAIL ovf_reset got=%b exp=0", bus.overflowOUT); end
        log_q.delete();
        put(8'h0C);
        n = 0;
        i = 0;
        while (i < 3000 && n < 1000) begin
            @(posedge clk); #1;
            n = log_q.size() + ((bus.wrEnOUT === 1'b1) ? 1 : 0);
            i++;
        end
        checks++;
        if (n != 1000) begin failures++; $display("FAIL midclear_reach got=%0d exp=1000", n); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks += 3;
        if (bus.wrEnOUT !== 1'b0) begin failures++; $display("FAIL midclear_wren got=%b exp=0", bus.wrEnOUT); end
        if (bus.busyOUT !== 1'b0) begin failures++; $display("FAIL midclear_busy got=%b exp=0", bus.busyOUT); end
        if (bus.cursorColOUT !== 7'd0 || bus.cursorRowOUT !== 5'd0) begin
            failures++; $display("FAIL midclear_cursor got=(%0d,%0d) exp=(0,0)", bus.cursorColOUT, bus.cursorRowOUT);
        end
        rst = 1'b0;
        repeat (50) @(negedge clk);
        checks += 2;
        if (log_q.size() != 1000) begin failures++; $display("FAIL midclear_total got=%0d exp=1000", log_q.size()); end
        if (log_q.size() >= 1000 && log_q[999].addr != 999) begin
            failures++; $display("FAIL midclear_last got=%0d exp=999", log_q[999].addr);
        end
        $display("test_reset_mid_clear writes=%0d", log_q.size());
    endtask

    initial begin
        bus.rxReadyIN = 1'b0;
        bus.rxDataIN  = 8'h00;
        test_reset();
        test_hello();
        test_hold();
        test_cursor();
        test_clear();
        test_overflow();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
